apb_slave_regs: RTL and testbench

- APB3 completer (responder): the other end of the bus driven by apb_master.
- Decodes word-aligned addresses into a bank of NUM_REGS read/write registers.
- Inserts a programmable number of wait states via pready; flags bad addresses via pslverr.
- Exposes register contents and a one-cycle write strobe to the attached IP block.

---
 rtl/apb_slave_regs.sv | 122 ++++++++++++
 tb/tb_apb_slave_regs.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regs.sv
// APB3 completer exposing NUM_REGS read/write registers, with programmable wait states,
// an error response for bad addresses, and a one-cycle write strobe for the attached block.
module apb_slave_regs #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0,
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           pclk,
    input  logic                           reset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic                           wr_strobe,
    output logic [IDX_W-1:0]               wr_index
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    write_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic                    wr_strobe_q;
    logic [IDX_W-1:0]        wr_index_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic [ADDR_WIDTH-3:0]   idx_full;
    logic                    addr_err;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic                    pready_w;
    logic                    setup_w;

    // Address decode on the live bus; only sampled at the setup edge.
    always_comb begin
        idx_full = paddr[ADDR_WIDTH-1:2];
        addr_err = (paddr[1:0] != 2'b00) || (32'(idx_full) >= 32'(NUM_REGS));
        rd_val   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_full == (ADDR_WIDTH-2)'(i)) rd_val = regs_q[i];
        end
    end

    assign setup_w = (state_q == IDLE) && psel && !penable;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (psel && !penable) state_d = ACCESS;
            ACCESS:  if (!psel || (penable && pready_w)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pready_w = (state_q == ACCESS) && (cnt_q == 4'd0);
        pready   = pready_w;
        pslverr  = pready_w && err_q;
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            prdata_q    <= '0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (setup_w) begin
                idx_q    <= idx_full[IDX_W-1:0];
                write_q  <= pwrite;
                wdata_q  <= pwdata;
                err_q    <= addr_err;
                cnt_q    <= 4'(WAIT_STATES);
                prdata_q <= addr_err ? '0 : rd_val;
            end else if (state_q == ACCESS) begin
                if (!psel) begin
                    prdata_q <= '0;
                end else if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else if (penable) begin
                    // Commit on the completion edge; the strobe follows one cycle later.
                    prdata_q <= '0;
                    if (write_q && !err_q) begin
                        regs_q[idx_q] <= wdata_q;
                        wr_strobe_q   <= 1'b1;
                        wr_index_q    <= idx_q;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign prdata    = prdata_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard bench for apb_slave_regs: three instances with WAIT_STATES 0, 2 and 3,
// directed transfers push expected responses, monitors pop them as the DUTs complete.
module tb_apb_slave_regs;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int IW = 3;
    localparam int ND = 3;

    typedef struct {
        int            dut;
        bit            rd;
        bit            err;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        int            dut;
        logic [IW-1:0] idx;
    } stb_t;

    logic              pclk;
    logic              rst_n     [ND];
    logic              psel      [ND];
    logic              penable   [ND];
    logic              pwrite    [ND];
    logic [AW-1:0]     paddr     [ND];
    logic [DW-1:0]     pwdata    [ND];
    logic [DW-1:0]     prdata    [ND];
    logic              pready    [ND];
    logic              pslverr   [ND];
    logic [NR*DW-1:0]  reg_out   [ND];
    logic              wr_strobe [ND];
    logic [IW-1:0]     wr_index  [ND];

    logic [NR*DW-1:0]  model [ND];
    rsp_t              sbq [$];
    stb_t              stq [$];
    int                tests = 0;
    int                fails = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        apb_slave_regs #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .NUM_REGS   (NR),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .pclk     (pclk),
            .reset    (rst_n[g]),
            .psel     (psel[g]),
            .penable  (penable[g]),
            .pwrite   (pwrite[g]),
            .paddr    (paddr[g]),
            .pwdata   (pwdata[g]),
            .prdata   (prdata[g]),
            .pready   (pready[g]),
            .pslverr  (pslverr[g]),
            .reg_out  (reg_out[g]),
            .wr_strobe(wr_strobe[g]),
            .wr_index (wr_index[g])
        );
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    // Response monitor and strobe monitor, sampled on the falling edge.
    always @(negedge pclk) begin
        rsp_t e;
        stb_t s;
        for (int d = 0; d < ND; d++) begin
            if (rst_n[d] && psel[d] && penable[d] && pready[d]) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected dut=%0d prdata=%h pslverr=%b, expected no response", d, prdata[d], pslverr[d]);
                end else begin
                    e = sbq.pop_front();
                    if (e.dut != d || pslverr[d] !== e.err || ((e.rd || e.err) && prdata[d] !== e.data)) begin
                        fails++;
                        $display("FAIL rsp dut=%0d prdata=%h pslverr=%b, expected dut=%0d prdata=%h pslverr=%b",
                                 d, prdata[d], pslverr[d], e.dut, e.data, e.err);
                    end
                end
            end
            if (rst_n[d] && psel[d] && penable[d] && !pready[d]) begin
                tests++;
                if (pslverr[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL pslverr_wait dut=%0d pslverr=%b, expected 0", d, pslverr[d]);
                end
            end
            if (wr_strobe[d] === 1'b1) begin
                tests++;
                if (stq.size() == 0) begin
                    fails++;
                    $display("FAIL strobe_unexpected dut=%0d wr_index=%0d, expected no strobe", d, wr_index[d]);
                end else begin
                    s = stq.pop_front();
                    if (s.dut != d || wr_index[d] !== s.idx) begin
                        fails++;
                        $display("FAIL strobe dut=%0d wr_index=%0d, expected dut=%0d wr_index=%0d", d, wr_index[d], s.dut, s.idx);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Starts on the cycle after an edge; leaves the bus idle one edge after completion,
    // so consecutive calls are back-to-back with no idle cycle.
    task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd, input bit exp_err);
        int waits;
        sbq.push_back('{dut: d, rd: !wr, err: exp_err, data: exp_rd});
        if (wr && !exp_err) begin
            model[d][32'(a[4:2])*DW +: DW] = wd;
            stq.push_back('{dut: d, idx: a[4:2]});
        end
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        waits = 0;
        while (!pready[d] && waits < 50) begin
            waits++;
            @(posedge pclk); #1;
        end
        check($sformatf("wait_states dut=%0d addr=%h", d, a), (NR*DW)'(waits), (NR*DW)'(ws_of(d)));
        @(posedge pclk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst_n[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; model[d] = '0;
        end
        repeat (3) @(posedge pclk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset_state dut=%0d", d),
                  (NR*DW)'({pready[d], pslverr[d], wr_strobe[d], wr_index[d], prdata[d]}), '0);
            check($sformatf("reset_regs dut=%0d", d), reg_out[d], '0);
            rst_n[d] = 1'b1;
        end
        @(posedge pclk); #1;

        // Zero wait states: write, read back, back-to-back writes, error transfers.
        xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, 32'h0, 1'b0);
        check("ws0_reg2", (NR*DW)'(reg_out[0][2*DW +: DW]), (NR*DW)'(32'hDEADBEEF));
        xfer(0, 1'b0, 8'h08, 32'h0, 32'hDEADBEEF, 1'b0);
        xfer(0, 1'b1, 8'h00, 32'h1, 32'h0, 1'b0);
        xfer(0, 1'b1, 8'h04, 32'h2, 32'h0, 1'b0);
        xfer(0, 1'b0, 8'h00, 32'h0, 32'h1, 1'b0);
        xfer(0, 1'b0, 8'h04, 32'h0, 32'h2, 1'b0);
        xfer(0, 1'b1, 8'h20, 32'hFFFF0000, 32'h0, 1'b1);
        xfer(0, 1'b1, 8'h06, 32'h0000FFFF, 32'h0, 1'b1);
        xfer(0, 1'b0, 8'h20, 32'h0, 32'h0, 1'b1);
        xfer(0, 1'b0, 8'h1C, 32'h0, 32'h0, 1'b0);
        check("ws0_regs_after_errors", reg_out[0], model[0]);

        // Two wait states: write/read, error during waits, aborted write.
        xfer(1, 1'b1, 8'h04, 32'hCAFEF00D, 32'h0, 1'b0);
        xfer(1, 1'b0, 8'h04, 32'h0, 32'hCAFEF00D, 1'b0);
        xfer(1, 1'b0, 8'h0A, 32'h0, 32'h0, 1'b1);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h0C; pwdata[1] = 32'h12345678;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        check("abort_in_wait_pready", (NR*DW)'(pready[1]), '0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge pclk); #1;
        check("abort_prdata", (NR*DW)'(prdata[1]), '0);
        check("abort_regs", reg_out[1], model[1]);
        xfer(1, 1'b0, 8'h0C, 32'h0, 32'h0, 1'b0);
        xfer(1, 1'b1, 8'h0C, 32'h0BADF00D, 32'h0, 1'b0);
        check("ws2_regs", reg_out[1], model[1]);

        // Three wait states: asynchronous reset in the middle of a read.
        xfer(2, 1'b1, 8'h08, 32'h00000055, 32'h0, 1'b0);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b0; paddr[2] = 8'h08;
        @(posedge pclk); #1;
        penable[2] = 1'b1;
        @(posedge pclk); #1;
        check("midaccess_prdata", (NR*DW)'(prdata[2]), (NR*DW)'(32'h55));
        rst_n[2] = 1'b0;
        #1;
        check("async_reset_outputs", (NR*DW)'({pready[2], pslverr[2], wr_strobe[2], prdata[2]}), '0);
        check("async_reset_regs", reg_out[2], '0);
        model[2] = '0;
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge pclk); #1;
        rst_n[2] = 1'b1;
        @(posedge pclk); #1;
        xfer(2, 1'b0, 8'h08, 32'h0, 32'h0, 1'b0);
        xfer(2, 1'b1, 8'h1C, 32'hA5A5A5A5, 32'h0, 1'b0);
        xfer(2, 1'b0, 8'h1C, 32'h0, 32'hA5A5A5A5, 1'b0);

        repeat (3) @(posedge pclk);
        #1;
        check("responses_outstanding", (NR*DW)'(sbq.size()), '0);
        check("strobes_outstanding", (NR*DW)'(stq.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d, expected completion", tests);
        $fatal(1, "timeout");
    end

endmodule
